dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Handshaked data-memory responder. It is the target end of the CPU load/store path: it accepts one word request at a time from a load/store initiator, inserts programmable wait states, then returns read data or a write acknowledge.
- Replaces the zero-latency combinational data memory once the core moves to a multi-cycle memory port.
- Storage is word-organised; a full mirror output is provided for benches.

Parameters:
- DEPTH, 32: number of 32-bit words; power of two, 2..1024.
- LATENCY, 2: wait-state cycles between request acceptance and the memory access edge; 0..15.
- AW, $clog2(DEPTH): word-index width; derived, not overridden.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset; the block is held in reset while low.
- init_values  in  32 x [0:DEPTH-1]  contents loaded into storage while reset is low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_wstrb  in  4  byte enables; bit i covers byte lane [8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator accepts response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_error  out  1  misaligned or out-of-range access.
- memory_check  out  32 x [0:DEPTH-1]  combinational copy of storage.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; req_ready = 0 while reset is low, 1 in the first cycle after release.
  - rsp_valid = 0, rsp_rdata = 0, rsp_error = 0, wait counter = 0.
  - storage[i] = init_values[i].
- FSM states: IDLE, WAIT, ACCESS, RESP.
  - req_ready = 1 only in IDLE; rsp_valid = 1 only in RESP.
- IDLE:
  - On req_valid && req_ready, capture write, addr, wdata, wstrb.
  - Go to WAIT with counter = LATENCY-1 if LATENCY > 0; otherwise go to ACCESS.
- WAIT: decrement the counter each cycle; when it is 0, go to ACCESS.
- ACCESS (exactly one cycle):
  - Compute error = (addr[1:0] != 0) || (addr[31:2] >= DEPTH).
  - On the edge leaving ACCESS:
    - Good write: update the selected bytes of storage[addr[AW+1:2]].
    - Good read: rsp_rdata <= storage[idx]. The read value is taken before any write at that same edge; no write is pending then.
    - Write or error: rsp_rdata <= 0.
    - rsp_error <= error. Errored writes never modify storage.
  - Next state: RESP.
- RESP:
  - Hold rsp_rdata and rsp_error stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE and clear rsp_rdata and rsp_error to 0.
- Timing:
  - Latency from the acceptance edge to the first rsp_valid cycle is LATENCY+2 cycles.
  - Minimum spacing between accepted requests is LATENCY+3 cycles.
  - No overlap of requests.
- req_valid while not ready: ignored. The initiator holds the request stable until accepted.
- rsp_ready high outside RESP: no effect.
- Reset mid-operation: the captured request is dropped. A write not yet past its ACCESS edge is never committed. Storage reloads from init_values.
- Word index uses req_addr[AW+1:2]. High address bits are checked for range, not truncated.

Optional Feature:
- Macro DMEM_WSTRB_EN.
- Defined: writes honour req_wstrb per byte lane. wstrb == 4'b0000 is a legal no-op write with a normal response.
- Undefined: req_wstrb is ignored and every good write updates all 32 bits. The port remains present.

Decomposition:
- Package dmem_pkg:
  - dmem_state_t enum (IDLE, WAIT, ACCESS, RESP).
  - localparam WORD_BYTES = 4.
  - function byte_merge(old, new, strb).
- One sub-module, dmem_array:
  - DEPTH x 32 storage with asynchronous-reset load from init_values.
  - Single write port with strobes and a registered read.
  - memory_check mirror.
- The FSM, wait counter and error check live in dmem_responder.

Test Plan:
- Reset release with init_values[3] = 32'hDEADBEEF, LATENCY = 2; load addr 0x0C at cycle 0 → rsp_valid first high at cycle 4, rsp_rdata = 32'hDEADBEEF, rsp_error = 0.
- Store addr 0x10, wdata 32'h12345678, wstrb 4'b1111, then load 0x10 → memory_check[4] = 32'h12345678 and load returns the same; with DMEM_WSTRB_EN, wstrb 4'b0010 and wdata 32'h0000AB00 over 0 gives 32'h0000AB00.
- Misaligned load 0x06 and store to 0x80 (DEPTH = 32) → rsp_error = 1, rsp_rdata = 0, storage unchanged.
- Backpressure: rsp_ready low for 5 cycles in RESP → rsp_valid and data held constant, req_ready stays 0; a second request accepted only after the handshake.
- LATENCY = 0: request accepted at cycle 0 → rsp_valid at cycle 2; back-to-back requests spaced by 3 cycles.
- Reset asserted during WAIT of a store to 0x08 → after release, storage[2] equals init_values[2], rsp_valid = 0, req_ready = 1.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the handshaked data-memory responder.
//   dmem_state_t : responder FSM states
//   WORD_BYTES   : byte lanes per storage word
//   byte_merge   : lane-wise merge of a new word into an old word
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } dmem_state_t;

  localparam int WORD_BYTES = 4;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0]           old_word,
                                             input logic [31:0]           new_word,
                                             input logic [WORD_BYTES-1:0] strb);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage for dmem_responder.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   init_values_i     : contents loaded into every word while reset is low
//   idx_i             : word index shared by the write and read ports
//   we_i, wdata_i,
//   wstrb_i           : single write port with byte-lane strobes
//   re_i              : load the read register from storage[idx_i]
//   clr_i             : clear the read register (ignored when re_i is high)
//   rdata_o           : registered read data
//   memory_check_o    : combinational mirror of every word
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           init_values_i [0:DEPTH-1],
  input  logic [AW-1:0]         idx_i,
  input  logic                  we_i,
  input  logic [31:0]           wdata_i,
  input  logic [WORD_BYTES-1:0] wstrb_i,
  input  logic                  re_i,
  input  logic                  clr_i,
  output logic [31:0]           rdata_o,
  output logic [31:0]           memory_check_o [0:DEPTH-1]
);

  logic [31:0] rdata_q;

  // One register per word so that the whole array can be (re)loaded from
  // init_values_i while reset is held low.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    logic [31:0] word_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        word_q <= init_values_i[gi];
      end else if (we_i && (idx_i == AW'(gi))) begin
        word_q <= byte_merge(word_q, wdata_i, wstrb_i);
      end
    end

    assign memory_check_o[gi] = word_q;
  end

  // Reads and writes are never issued in the same cycle, so the read
  // register always sees the pre-write contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= memory_check_o[idx_i];
    end else if (clr_i) begin
      rdata_q <= '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: accepts one word request at a time,
// waits LATENCY cycles, performs the access in a single ACCESS cycle, then
// presents the response until the initiator takes it.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   init_values         : storage contents loaded while reset is low
//   req_valid/req_ready : request handshake (ready only in IDLE)
//   req_write, req_addr,
//   req_wdata, req_wstrb: request payload (byte address, byte strobes)
//   rsp_valid/rsp_ready : response handshake (valid only in RESP)
//   rsp_rdata, rsp_error: load data (0 for stores/errors), access error
//   memory_check        : combinational copy of storage
// Build option: DMEM_WSTRB_EN - when defined, writes honour req_wstrb per
// byte lane; otherwise every good write replaces the whole word.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int  DEPTH   = 32,
  parameter int  LATENCY = 2,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] init_values [0:DEPTH-1],
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] memory_check [0:DEPTH-1]
);

  localparam int CNT_W = 4;

  dmem_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic             err_q;

  logic             accept;
  logic             rsp_done;
  logic             access_err;
  logic             in_access;
  logic [3:0]       wstrb_eff;

  // req_ready is gated by reset so it reads 0 while reset is held low.
  assign req_ready = reset && (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign accept    = req_valid && req_ready;
  assign rsp_done  = rsp_valid && rsp_ready;
  assign in_access = (state_q == ACCESS);

  // High address bits are range-checked rather than truncated away.
  assign access_err = (addr_q[1:0] != 2'b00) ||
                      ({2'b00, addr_q[31:2]} >= 32'(DEPTH));

`ifdef DMEM_WSTRB_EN
  assign wstrb_eff = wstrb_q;
`else
  assign wstrb_eff = '1;
  logic unused_wstrb;
  assign unused_wstrb = ^wstrb_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end
      if (in_access) begin
        err_q <= access_err;
      end else if (rsp_done) begin
        err_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = ACCESS;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ACCESS: state_d = RESP;
      RESP:   if (rsp_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rsp_error = err_q;

  // Writes/errors clear the read register at the ACCESS edge; a completed
  // response handshake clears it again so it idles at zero.
  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk            (clk),
    .reset          (reset),
    .init_values_i  (init_values),
    .idx_i          (addr_q[AW+1:2]),
    .we_i           (in_access && write_q && !access_err),
    .wdata_i        (wdata_q),
    .wstrb_i        (wstrb_eff),
    .re_i           (in_access && !write_q && !access_err),
    .clr_i          ((in_access && (write_q || access_err)) || rsp_done),
    .rdata_o        (rsp_rdata),
    .memory_check_o (memory_check)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with LATENCY=2 (unit 0) and one
// with LATENCY=0 (unit 1), checked against a word-array reference model.
module tb_dmem_responder;

  localparam int DEPTH = 32;
  localparam int LAT0  = 2;
  localparam int LAT1  = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] init_values [0:DEPTH-1];

  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wstrb [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_error [2];
  logic [31:0] mc_a [0:DEPTH-1];
  logic [31:0] mc_b [0:DEPTH-1];

  logic [31:0] model [2][DEPTH];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT0)) dut_a (
    .clk(clk), .reset(reset), .init_values(init_values),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_error(rsp_error[0]), .memory_check(mc_a)
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT1)) dut_b (
    .clk(clk), .reset(reset), .init_values(init_values),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_error(rsp_error[1]), .memory_check(mc_b)
  );

  function automatic int lat_of(input int u);
    return (u == 0) ? LAT0 : LAT1;
  endfunction

  // Reference model: word array addressed by byte address / 4.
  function automatic void model_access(input int u, input logic wr, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [3:0] strb,
                                       output logic [31:0] exp_rdata, output logic exp_err);
    int idx;
    logic [3:0] en;
    exp_err   = (addr % 4 != 0) || ((addr / 4) >= DEPTH);
    exp_rdata = 32'h0;
`ifdef DMEM_WSTRB_EN
    en = strb;
`else
    en = 4'hF;
`endif
    if (!exp_err) begin
      idx = int'(addr / 4);
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (en[b]) model[u][idx][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        exp_rdata = model[u][idx];
      end
    end
  endfunction

  function automatic void model_reload();
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < DEPTH; i++) model[u][i] = init_values[i];
  endfunction

  function automatic int mem_diff(input int u);
    int n;
    n = 0;
    for (int i = 0; i < DEPTH; i++)
      if (((u == 0) ? mc_a[i] : mc_b[i]) !== model[u][i]) n++;
    return n;
  endfunction

  // Drives one request and returns what was observed; callers compare.
  // Returns #1 after the response handshake edge.
  task automatic do_txn(input int u, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb, input int hold,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output logic held_ok, output int acc_cyc);
    int n;
    lat = -1; rdata = 'x; err = 1'bx; held_ok = 1'b1; acc_cyc = -1;
    req_valid[u] = 1'b1; req_write[u] = wr; req_addr[u] = addr;
    req_wdata[u] = wdata; req_wstrb[u] = strb;
    n = 0;
    while (req_ready[u] !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (req_ready[u] !== 1'b1) begin req_valid[u] = 1'b0; return; end
    @(posedge clk); #1;
    acc_cyc = cyc;
    req_valid[u] = 1'b0;
    req_addr[u] = $urandom; req_wdata[u] = $urandom; req_write[u] = 1'($urandom);
    n = 1;
    while (rsp_valid[u] !== 1'b1 && n < 50) begin
      if (req_ready[u] !== 1'b0) held_ok = 1'b0;
      @(posedge clk); #1; n++;
    end
    if (rsp_valid[u] !== 1'b1) return;
    lat = n; rdata = rsp_rdata[u]; err = rsp_error[u];
    repeat (hold) begin
      @(posedge clk); #1;
      if (rsp_valid[u] !== 1'b1 || rsp_rdata[u] !== rdata ||
          rsp_error[u] !== err || req_ready[u] !== 1'b0) held_ok = 1'b0;
    end
    rsp_ready[u] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[u] = 1'b0;
    $display("txn u=%0d wr=%0d addr=%h wdata=%h strb=%b lat=%0d rdata=%h err=%0d",
             u, wr, addr, wdata, strb, lat, rdata, err);
  endtask

  task automatic test_reset();
    for (int i = 0; i < DEPTH; i++) init_values[i] = $urandom;
    init_values[3] = 32'hDEADBEEF;
    init_values[5] = 32'h0;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 0; req_write[u] = 0; req_addr[u] = 0;
      req_wdata[u] = 0; req_wstrb[u] = 0; rsp_ready[u] = 0;
    end
    reset = 1'b0;
    model_reload();
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (req_ready[u] !== 1'b0 || rsp_valid[u] !== 1'b0 || rsp_rdata[u] !== 32'h0 ||
          rsp_error[u] !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs u=%0d got rdy=%b vld=%b rdata=%h err=%b exp 0/0/0/0",
                 u, req_ready[u], rsp_valid[u], rsp_rdata[u], rsp_error[u]);
      end
      checks++;
      if (mem_diff(u) !== 0) begin
        failures++;
        $display("FAIL reset_storage u=%0d got %0d differing words exp 0", u, mem_diff(u));
      end
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (req_ready[u] !== 1'b1) begin
        failures++;
        $display("FAIL reset_release_ready u=%0d got %b exp 1", u, req_ready[u]);
      end
    end
  endtask

  task automatic run_checked(input int u, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] strb, input int hold,
                             input string tag);
    int lat, acc; logic [31:0] rd, exp_rd; logic er, exp_er, ok;
    model_access(u, wr, addr, wdata, strb, exp_rd, exp_er);
    do_txn(u, wr, addr, wdata, strb, hold, lat, rd, er, ok, acc);
    checks++;
    if (lat !== lat_of(u) + 2) begin
      failures++; $display("FAIL %s_latency u=%0d got %0d exp %0d", tag, u, lat, lat_of(u) + 2);
    end
    checks++;
    if (rd !== exp_rd || er !== exp_er) begin
      failures++;
      $display("FAIL %s_response u=%0d addr=%h got rdata=%h err=%b exp rdata=%h err=%b",
               tag, u, addr, rd, er, exp_rd, exp_er);
    end
    checks++;
    if (ok !== 1'b1) begin
      failures++; $display("FAIL %s_hold u=%0d got unstable exp stable", tag, u);
    end
    checks++;
    if (rsp_valid[u] !== 1'b0 || rsp_rdata[u] !== 32'h0 || rsp_error[u] !== 1'b0 ||
        req_ready[u] !== 1'b1) begin
      failures++;
      $display("FAIL %s_after_handshake u=%0d got vld=%b rdata=%h err=%b rdy=%b exp 0/0/0/1",
               tag, u, rsp_valid[u], rsp_rdata[u], rsp_error[u], req_ready[u]);
    end
    checks++;
    if (mem_diff(u) !== 0) begin
      failures++; $display("FAIL %s_storage u=%0d got %0d differing words exp 0", tag, u, mem_diff(u));
    end
  endtask

  task automatic test_init_load();
    run_checked(0, 1'b0, 32'h0000_000C, 32'h0, 4'h0, 0, "init_load");
  endtask

  task automatic test_store_load();
    logic        wr [4]   = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ad [4]   = '{32'h10, 32'h10, 32'h14, 32'h14};
    logic [31:0] wd [4]   = '{32'h12345678, 32'h0, 32'h0000AB00, 32'h0};
    logic [3:0]  st [4]   = '{4'b1111, 4'b0000, 4'b0010, 4'b0000};
    for (int k = 0; k < 4; k++) run_checked(0, wr[k], ad[k], wd[k], st[k], 0, "store_load");
    checks++;
    if (mc_a[4] !== 32'h12345678) begin
      failures++; $display("FAIL store_word4 got %h exp 12345678", mc_a[4]);
    end
    checks++;
    if (mc_a[5] !== 32'h0000AB00) begin
      failures++; $display("FAIL store_word5 got %h exp 0000ab00", mc_a[5]);
    end
  endtask

  task automatic test_errors();
    run_checked(0, 1'b0, 32'h0000_0006, 32'h0, 4'h0, 0, "err_misaligned_load");
    run_checked(0, 1'b1, 32'h0000_0080, 32'hCAFEF00D, 4'hF, 0, "err_range_store");
    run_checked(0, 1'b1, 32'h8000_0010, 32'hCAFEF00D, 4'hF, 0, "err_high_store");
    run_checked(1, 1'b1, 32'h0000_0011, 32'hCAFEF00D, 4'hF, 0, "err_misaligned_store");
    run_checked(1, 1'b0, 32'h0001_0000, 32'h0, 4'h0, 0, "err_range_load");
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 3; k++)
      run_checked(0, 1'($urandom), 32'($urandom_range(0, DEPTH - 1)) << 2, $urandom,
                  4'($urandom), 5, "backpressure");
  endtask

  task automatic test_random();
    logic [31:0] a;
    int kind;
    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 9);
      if (kind < 8)       a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      else if (kind == 8) a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      else                a = $urandom | 32'h0000_0080;
      run_checked(k % 2, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_back_to_back();
    int lat, acc, prev; logic [31:0] rd, exp_rd; logic er, exp_er, ok, wr;
    logic [31:0] a, wd; logic [3:0] st;
    for (int u = 0; u < 2; u++) begin
      prev = -1;
      for (int k = 0; k < 6; k++) begin
        wr = 1'($urandom); a = 32'($urandom_range(0, DEPTH - 1)) << 2;
        wd = $urandom; st = 4'($urandom);
        model_access(u, wr, a, wd, st, exp_rd, exp_er);
        do_txn(u, wr, a, wd, st, 0, lat, rd, er, ok, acc);
        checks++;
        if (rd !== exp_rd || er !== exp_er || lat !== lat_of(u) + 2) begin
          failures++;
          $display("FAIL b2b_response u=%0d got rdata=%h err=%b lat=%0d exp rdata=%h err=%b lat=%0d",
                   u, rd, er, lat, exp_rd, exp_er, lat_of(u) + 2);
        end
        if (prev >= 0) begin
          checks++;
          if (acc - prev !== lat_of(u) + 3) begin
            failures++;
            $display("FAIL b2b_spacing u=%0d got %0d exp %0d", u, acc - prev, lat_of(u) + 3);
          end
        end
        prev = acc;
      end
    end
  endtask

  task automatic test_reset_midop();
    int n;
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h08;
    req_wdata[0] = ~model[0][2]; req_wstrb[0] = 4'hF;
    n = 0;
    while (req_ready[0] !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    init_values[7] = $urandom;
    #1;
    model_reload();
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    $display("txn u=0 reset during WAIT of store addr=00000008");
    checks++;
    if (mc_a[2] !== init_values[2]) begin
      failures++; $display("FAIL midop_word2 got %h exp %h", mc_a[2], init_values[2]);
    end
    checks++;
    if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL midop_state got vld=%b rdy=%b exp 0/1", rsp_valid[0], req_ready[0]);
    end
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (mem_diff(u) !== 0) begin
        failures++; $display("FAIL midop_reload u=%0d got %0d differing words exp 0", u, mem_diff(u));
      end
    end
    run_checked(0, 1'b0, 32'h08, 32'h0, 4'h0, 0, "midop_load");
  endtask

  initial begin
    test_reset();
    test_init_load();
    test_store_load();
    test_errors();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
